// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard control.
// Holds the forwarding-select encoding and the scoreboard wait-time rule.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  localparam int REG_ZERO            = 0;
  localparam int DEFAULT_MEM_LATENCY = 1;

  // Cycles until a result can be consumed through the fastest available path.
  function automatic int sb_wait(input logic is_load, input logic fwd_en, input int mem_lat);
    return (is_load || !fwd_en) ? (1 + mem_lat) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_sb_entry.sv
// One scoreboard slot: a down-counter of cycles until its register's value is usable.
// A new issue to the same register overrides the running decrement.
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard control for the 5-stage pipeline: scoreboard RAW stalls, redirect flush,
// EX/ID forwarding selects and saturating stall/flush counters.
module hazard_scoreboard_unit
  import mips_pipe_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_SRC     = 2,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int FWD_EN      = 1,
  parameter int PERF_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_global_hold,
  input  logic                          i_id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_src_addr,
  input  logic [NUM_SRC-1:0]            i_id_src_used,
  input  logic                          i_id_is_branch,
  input  logic                          i_id_reg_write,
  input  logic [REG_ADDR_W-1:0]         i_id_dst,
  input  logic                          i_id_is_load,
  input  logic                          i_id_redirect,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_ex_src_addr,
  input  logic                          i_mem_reg_write,
  input  logic                          i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0]         i_mem_dst,
  input  logic [REG_ADDR_W-1:0]         i_wb_dst,
  output logic                          o_pc_en,
  output logic                          o_if_id_en,
  output logic                          o_if_id_clear,
  output logic                          o_id_ex_clear,
  output logic                          o_stall,
  output logic [2*NUM_SRC-1:0]          o_fwd_ex_sel,
  output logic [NUM_SRC-1:0]            o_fwd_id_sel,
  output logic [PERF_W-1:0]             o_stall_count,
  output logic [PERF_W-1:0]             o_flush_count
);

  localparam int CNT_W     = $clog2(MEM_LATENCY + 2);
  localparam int NUM_SLOTS = 2 ** REG_ADDR_W;

  // Slots for $0 and for addresses beyond NUM_REGS read as permanently ready.
  logic [CNT_W-1:0]      cnt [NUM_SLOTS];
  logic [CNT_W-1:0]      wait_val;
  logic [CNT_W-1:0]      src_cnt;
  logic [REG_ADDR_W-1:0] id_a;
  logic [REG_ADDR_W-1:0] ex_a;
  logic                  hazard;
  logic                  issue;
  fwd_sel_t              ex_sel;

  assign wait_val = CNT_W'(sb_wait(i_id_is_load, FWD_EN != 0, MEM_LATENCY));
  assign issue    = i_id_valid & ~o_stall & ~i_global_hold & i_id_reg_write &
                    (i_id_dst != REG_ADDR_W'(REG_ZERO));

  for (genvar r = 0; r < NUM_SLOTS; r++) begin : g_sb
    if (r == REG_ZERO || r >= NUM_REGS) begin : g_idle
      assign cnt[r] = '0;
    end else begin : g_entry
      sb_entry #(.CNT_W(CNT_W)) u_entry (
        .clk      (i_clk),
        .rst      (i_rst),
        .hold     (i_global_hold),
        .load     (issue && (i_id_dst == REG_ADDR_W'(r))),
        .load_val (wait_val),
        .cnt      (cnt[r])
      );
    end
  end

  // A branch compares in ID, so it cannot use the EX-stage forward a plain ALU op gets.
  always_comb begin
    hazard  = 1'b0;
    src_cnt = '0;
    id_a    = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      id_a    = i_id_src_addr[s*REG_ADDR_W +: REG_ADDR_W];
      src_cnt = cnt[id_a];
      if (i_id_src_used[s] && id_a != REG_ADDR_W'(REG_ZERO)) begin
        if (FWD_EN != 0 && !i_id_is_branch) begin
          hazard = hazard | (src_cnt > CNT_W'(1));
        end else begin
          hazard = hazard | (src_cnt != '0);
        end
      end
    end
  end

  assign o_stall       = i_id_valid & hazard & ~i_global_hold;
  assign o_pc_en       = ~i_global_hold & ~o_stall;
  assign o_if_id_en    = ~i_global_hold & ~o_stall;
  assign o_id_ex_clear = o_stall;
  assign o_if_id_clear = i_id_redirect & ~o_stall & ~i_global_hold;

  always_comb begin
    o_fwd_ex_sel = '0;
    o_fwd_id_sel = '0;
    ex_sel       = FWD_RF;
    ex_a         = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      ex_a   = i_ex_src_addr[s*REG_ADDR_W +: REG_ADDR_W];
      ex_sel = FWD_RF;
      if (FWD_EN != 0 && ex_a != REG_ADDR_W'(REG_ZERO)) begin
        if (i_mem_reg_write && i_mem_dst == ex_a) begin
          ex_sel = FWD_EXMEM;
        end else if (i_wb_reg_write && i_wb_dst == ex_a) begin
          ex_sel = FWD_MEMWB;
        end
      end
      o_fwd_ex_sel[2*s +: 2] = ex_sel;
      if (FWD_EN != 0 && i_id_src_addr[s*REG_ADDR_W +: REG_ADDR_W] != REG_ADDR_W'(REG_ZERO) &&
          i_mem_reg_write && i_mem_dst == i_id_src_addr[s*REG_ADDR_W +: REG_ADDR_W]) begin
        o_fwd_id_sel[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_count <= '0;
      o_flush_count <= '0;
    end else if (!i_global_hold) begin
      if (o_stall && o_stall_count != '1) begin
        o_stall_count <= o_stall_count + 1'b1;
      end
      if (o_if_id_clear && o_flush_count != '1) begin
        o_flush_count <= o_flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: a forwarding build (dut 0) and a no-forwarding,
// two-cycle-memory build (dut 1) share stimulus; directed table, sequences, random.
module tb_hazard_scoreboard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] src0;
    logic [4:0] src1;
    logic [1:0] used;
    logic       br;
    logic       rw;
    logic [4:0] dst;
    logic       ld;
    logic       redir;
    logic       hold;
    logic [4:0] ex0;
    logic [4:0] ex1;
    logic       mrw;
    logic [4:0] mdst;
    logic       wrw;
    logic [4:0] wdst;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       pc_en;
    logic       ifclr;
    logic       idex;
    logic [3:0] fex;
    logic [1:0] fid;
    logic [3:0] scnt;
    logic [3:0] fcnt;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t want;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       global_hold, id_valid, id_is_branch, id_reg_write, id_is_load, id_redirect;
  logic [9:0] id_src_addr, ex_src_addr;
  logic [1:0] id_src_used;
  logic [4:0] id_dst, mem_dst, wb_dst;
  logic       mem_reg_write, wb_reg_write;

  logic [1:0] pc_en, if_id_en, if_id_clear, id_ex_clear, stall;
  logic [3:0] fex  [2];
  logic [1:0] fid  [2];
  logic [3:0] scnt [2];
  logic [3:0] fcnt [2];

  hazard_scoreboard_unit #(.FWD_EN(1), .MEM_LATENCY(1), .PERF_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_global_hold(global_hold), .i_id_valid(id_valid),
    .i_id_src_addr(id_src_addr), .i_id_src_used(id_src_used), .i_id_is_branch(id_is_branch),
    .i_id_reg_write(id_reg_write), .i_id_dst(id_dst), .i_id_is_load(id_is_load),
    .i_id_redirect(id_redirect), .i_ex_src_addr(ex_src_addr),
    .i_mem_reg_write(mem_reg_write), .i_wb_reg_write(wb_reg_write),
    .i_mem_dst(mem_dst), .i_wb_dst(wb_dst),
    .o_pc_en(pc_en[0]), .o_if_id_en(if_id_en[0]), .o_if_id_clear(if_id_clear[0]),
    .o_id_ex_clear(id_ex_clear[0]), .o_stall(stall[0]), .o_fwd_ex_sel(fex[0]),
    .o_fwd_id_sel(fid[0]), .o_stall_count(scnt[0]), .o_flush_count(fcnt[0])
  );

  hazard_scoreboard_unit #(.FWD_EN(0), .MEM_LATENCY(2), .PERF_W(4)) dut_nf (
    .i_clk(clk), .i_rst(rst), .i_global_hold(global_hold), .i_id_valid(id_valid),
    .i_id_src_addr(id_src_addr), .i_id_src_used(id_src_used), .i_id_is_branch(id_is_branch),
    .i_id_reg_write(id_reg_write), .i_id_dst(id_dst), .i_id_is_load(id_is_load),
    .i_id_redirect(id_redirect), .i_ex_src_addr(ex_src_addr),
    .i_mem_reg_write(mem_reg_write), .i_wb_reg_write(wb_reg_write),
    .i_mem_dst(mem_dst), .i_wb_dst(wb_dst),
    .o_pc_en(pc_en[1]), .o_if_id_en(if_id_en[1]), .o_if_id_clear(if_id_clear[1]),
    .o_id_ex_clear(id_ex_clear[1]), .o_stall(stall[1]), .o_fwd_ex_sel(fex[1]),
    .o_fwd_id_sel(fid[1]), .o_stall_count(scnt[1]), .o_flush_count(fcnt[1])
  );

  int checks   = 0;
  int failures = 0;

  // reference model: each register's ready time on a clock of non-hold cycles
  int now_t  [2];
  int avail  [2][32];
  int m_scnt [2];
  int m_fcnt [2];
  logic [17:0] exp_q[$];

  function automatic in_t id_in(input int valid, s0, s1, used, br, rw, dst, ld, redir, hold);
    in_t x;
    x = '0;
    x.valid = 1'(valid); x.src0 = 5'(s0); x.src1 = 5'(s1); x.used = 2'(used);
    x.br = 1'(br); x.rw = 1'(rw); x.dst = 5'(dst); x.ld = 1'(ld);
    x.redir = 1'(redir); x.hold = 1'(hold);
    return x;
  endfunction

  function automatic in_t with_ex(input in_t b, input int e0, e1, mrw, mdst, wrw, wdst);
    in_t x;
    x = b;
    x.ex0 = 5'(e0); x.ex1 = 5'(e1); x.mrw = 1'(mrw); x.mdst = 5'(mdst);
    x.wrw = 1'(wrw); x.wdst = 5'(wdst);
    return x;
  endfunction

  function automatic out_t want_of(input int st, pc, ic, idc, fx, fi, sc, fc);
    out_t o;
    o.stall = 1'(st); o.pc_en = 1'(pc); o.ifclr = 1'(ic); o.idex = 1'(idc);
    o.fex = 4'(fx); o.fid = 2'(fi); o.scnt = 4'(sc); o.fcnt = 4'(fc);
    return o;
  endfunction

  function automatic out_t act_out(input int k);
    out_t a;
    a.stall = stall[k]; a.pc_en = pc_en[k]; a.ifclr = if_id_clear[k]; a.idex = id_ex_clear[k];
    a.fex = fex[k]; a.fid = fid[k]; a.scnt = scnt[k]; a.fcnt = fcnt[k];
    return a;
  endfunction

  function automatic out_t model_out(input int k, input in_t x);
    out_t o;
    bit fwd, haz;
    int rem;
    logic [4:0] a, e;
    logic [1:0] sel;
    fwd = (k == 0);
    haz = 1'b0;
    o = '0;
    for (int s = 0; s < 2; s++) begin
      a = (s == 0) ? x.src0 : x.src1;
      e = (s == 0) ? x.ex0 : x.ex1;
      rem = avail[k][a] - now_t[k];
      if (rem < 0) rem = 0;
      if (x.used[s] && a != 0) begin
        if (fwd && !x.br) haz = haz | (rem > 1);
        else              haz = haz | (rem > 0);
      end
      sel = 2'd0;
      if (fwd && e != 0) begin
        if (x.mrw && x.mdst == e)      sel = 2'd1;
        else if (x.wrw && x.wdst == e) sel = 2'd2;
      end
      o.fex[2*s +: 2] = sel;
      o.fid[s] = fwd && a != 0 && x.mrw && x.mdst == a;
    end
    o.stall = x.valid & haz & ~x.hold;
    o.pc_en = ~x.hold & ~o.stall;
    o.idex  = o.stall;
    o.ifclr = x.redir & ~o.stall & ~x.hold;
    o.scnt  = 4'(m_scnt[k]);
    o.fcnt  = 4'(m_fcnt[k]);
    return o;
  endfunction

  task automatic model_step(input int k, input in_t x);
    out_t o;
    int ml;
    o  = model_out(k, x);
    ml = (k == 0) ? 1 : 2;
    if (!x.hold) begin
      if (o.stall && m_scnt[k] < 15) m_scnt[k]++;
      if (o.ifclr && m_fcnt[k] < 15) m_fcnt[k]++;
      if (x.valid && !o.stall && x.rw && x.dst != 0)
        avail[k][x.dst] = now_t[k] + 1 + ((x.ld || k == 1) ? 1 + ml : 1);
      now_t[k]++;
    end
  endtask

  // driver tasks
  task automatic drive(input in_t x);
    global_hold   = x.hold;
    id_valid      = x.valid;
    id_src_addr   = {x.src1, x.src0};
    id_src_used   = x.used;
    id_is_branch  = x.br;
    id_reg_write  = x.rw;
    id_dst        = x.dst;
    id_is_load    = x.ld;
    id_redirect   = x.redir;
    ex_src_addr   = {x.ex1, x.ex0};
    mem_reg_write = x.mrw;
    mem_dst       = x.mdst;
    wb_reg_write  = x.wrw;
    wb_dst        = x.wdst;
  endtask

  task automatic step(input in_t x);
    drive(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      now_t[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
      for (int r = 0; r < 32; r++) avail[k][r] = 0;
    end
  endtask

  // scoreboard compare helpers
  task automatic check_vec(input string name, input int k, input out_t want);
    out_t got;
    got = act_out(k);
    checks++;
    if (got != want || if_id_en[k] != want.pc_en) begin
      failures++;
      $display("FAIL %s dut%0d got=%h want=%h if_id_en=%b", name, k, got, want, if_id_en[k]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.valid = ($urandom_range(0, 3) != 0);
    x.src0  = 5'($urandom_range(0, 7));
    x.src1  = 5'($urandom_range(0, 7));
    x.used  = 2'($urandom_range(0, 3));
    x.br    = ($urandom_range(0, 3) == 0);
    x.rw    = ($urandom_range(0, 2) != 0);
    x.dst   = 5'($urandom_range(0, 7));
    x.ld    = ($urandom_range(0, 2) == 0);
    x.redir = ($urandom_range(0, 7) == 0);
    x.hold  = ($urandom_range(0, 9) == 0);
    x.ex0   = 5'($urandom_range(0, 7));
    x.ex1   = 5'($urandom_range(0, 7));
    x.mrw   = 1'($urandom_range(0, 1));
    x.mdst  = 5'($urandom_range(0, 7));
    x.wrw   = 1'($urandom_range(0, 1));
    x.wdst  = 5'($urandom_range(0, 7));
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    in_t  idle, cons, x;
    int   n, hold_left;
    bit   bad, done;

    idle = '0;
    vt.push_back('{idle,                                            want_of(0,1,0,0,0,0,0,0)});
    vt.push_back('{id_in(1,0,0,0,0,1,2,1,0,0),                      want_of(0,1,0,0,0,0,0,0)});
    vt.push_back('{id_in(1,2,4,3,0,1,3,0,0,0),                      want_of(1,0,0,1,0,0,0,0)});
    vt.push_back('{id_in(1,2,4,3,0,1,3,0,0,0),                      want_of(0,1,0,0,0,0,1,0)});
    vt.push_back('{with_ex(idle,2,4,0,0,1,2),                       want_of(0,1,0,0,2,0,1,0)});
    vt.push_back('{id_in(1,0,0,0,0,1,5,0,0,0),                      want_of(0,1,0,0,0,0,1,0)});
    vt.push_back('{id_in(1,5,0,3,1,0,0,0,0,0),                      want_of(1,0,0,1,0,0,1,0)});
    vt.push_back('{with_ex(id_in(1,5,0,3,1,0,0,0,0,0),0,0,1,5,0,0), want_of(0,1,0,0,0,1,2,0)});
    vt.push_back('{id_in(1,0,0,0,0,1,6,0,0,0),                      want_of(0,1,0,0,0,0,2,0)});
    vt.push_back('{id_in(1,6,1,3,0,1,7,0,0,0),                      want_of(0,1,0,0,0,0,2,0)});
    vt.push_back('{with_ex(idle,6,1,1,6,0,0),                       want_of(0,1,0,0,1,0,2,0)});
    vt.push_back('{id_in(1,0,0,0,0,0,0,0,1,0),                      want_of(0,1,1,0,0,0,2,0)});
    vt.push_back('{idle,                                            want_of(0,1,0,0,0,0,2,1)});
    vt.push_back('{id_in(1,0,0,0,0,1,8,1,0,0),                      want_of(0,1,0,0,0,0,2,1)});
    vt.push_back('{id_in(1,8,0,1,1,0,0,0,1,0),                      want_of(1,0,0,1,0,0,2,1)});
    vt.push_back('{id_in(1,8,0,1,1,0,0,0,1,0),                      want_of(1,0,0,1,0,0,3,1)});
    vt.push_back('{id_in(1,8,0,1,1,0,0,0,1,0),                      want_of(0,1,1,0,0,0,4,1)});
    vt.push_back('{idle,                                            want_of(0,1,0,0,0,0,4,2)});
    vt.push_back('{id_in(1,0,0,0,0,1,0,1,0,0),                      want_of(0,1,0,0,0,0,4,2)});
    vt.push_back('{id_in(1,0,0,3,1,0,0,0,0,0),                      want_of(0,1,0,0,0,0,4,2)});
    vt.push_back('{with_ex(idle,9,9,1,9,1,9),                       want_of(0,1,0,0,5,0,4,2)});
    vt.push_back('{with_ex(idle,0,3,1,0,1,3),                       want_of(0,1,0,0,8,0,4,2)});
    vt.push_back('{id_in(1,0,0,0,0,1,2,1,0,0),                      want_of(0,1,0,0,0,0,4,2)});
    vt.push_back('{id_in(1,2,0,1,0,0,0,0,1,1),                      want_of(0,0,0,0,0,0,4,2)});
    vt.push_back('{id_in(1,2,0,1,0,0,0,0,1,0),                      want_of(1,0,0,1,0,0,4,2)});
    vt.push_back('{id_in(1,2,0,1,0,0,0,0,1,0),                      want_of(0,1,1,0,0,0,5,2)});
    vt.push_back('{idle,                                            want_of(0,1,0,0,0,0,5,3)});

    // reset state
    drive(idle);
    @(negedge clk);
    check_vec("reset", 0, want_of(0,1,0,0,0,0,0,0));
    check_vec("reset", 1, want_of(0,1,0,0,0,0,0,0));
    do_reset();

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].stim);
      @(negedge clk);
      check_vec($sformatf("table_row%0d", i), 0, vt[i].want);
      @(posedge clk);
      #1;
    end

    // no forwarding, two-cycle memory: three stall cycles, selects forced to RF
    do_reset();
    step(id_in(1,0,0,0,0,1,7,0,0,0));
    cons = with_ex(id_in(1,7,0,1,0,1,10,0,0,0),7,0,1,7,1,7);
    n = 0; bad = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(cons);
      @(negedge clk);
      if (fex[1] != 0 || fid[1] != 0) bad = 1;
      if (stall[1]) n++; else done = 1;
      @(posedge clk);
      #1;
    end
    check_int("nofwd_stall_len", done ? n : -1, 3);
    check_int("nofwd_sel_zero", int'(bad), 0);

    // asynchronous reset mid-stall
    do_reset();
    step(id_in(1,0,0,0,0,1,2,1,0,0));
    cons = id_in(1,2,0,1,0,1,3,0,0,0);
    drive(cons);
    @(negedge clk);
    check_int("rst_pre_stall", int'(stall[0]), 1);
    #1 rst = 1'b1;
    #1;
    check_int("rst_async_stall", int'(stall[0]), 0);
    check_int("rst_async_pc_en", int'(pc_en[0]), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("rst_cnt_clear", int'(stall[0]), 0);
    check_int("rst_perf_clear", int'(scnt[0]), 0);
    @(posedge clk);
    #1;

    // hold inserted mid-stall leaves the non-hold stall length unchanged
    do_reset();
    step(id_in(1,0,0,0,0,1,7,0,0,0));
    cons = id_in(1,7,0,1,0,1,10,0,0,0);
    n = 0; bad = 0; done = 0; hold_left = 4;
    for (int i = 0; i < 20 && !done; i++) begin
      x = cons;
      x.hold = (n == 1 && hold_left > 0);
      drive(x);
      @(negedge clk);
      if (x.hold) begin
        hold_left--;
        if (stall[1] || pc_en[1]) bad = 1;
      end else if (stall[1]) begin
        n++;
      end else begin
        done = 1;
        check_int("hold_perf_count", int'(scnt[1]), 3);
      end
      @(posedge clk);
      #1;
    end
    check_int("hold_stall_len", done ? n : -1, 3);
    check_int("hold_outputs", int'(bad), 0);

    // stall counter saturation: 2**4+3 stalls
    do_reset();
    for (int i = 0; i < 19; i++) begin
      if (i == 10) check_int("perf_mid", int'(scnt[0]), 10);
      step(id_in(1,0,0,0,0,1,2,1,0,0));
      step(id_in(1,2,0,1,0,1,3,0,0,0));
      step(id_in(1,2,0,1,0,1,3,0,0,0));
    end
    check_int("perf_saturate", int'(scnt[0]), 15);
    check_int("perf_flush_idle", int'(fcnt[0]), 0);

    // randomized run against the reference model, both builds
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      x = rand_in();
      drive(x);
      @(negedge clk);
      for (int k = 0; k < 2; k++) exp_q.push_back(model_out(k, x));
      for (int k = 0; k < 2; k++) check_vec("random", k, out_t'(exp_q.pop_front()));
      @(posedge clk);
      model_step(0, x);
      model_step(1, x);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
